wb_commit_buf: RTL
==================

# wb_commit_buf

Parametrised writeback stage for the 5-stage MIPS core, sitting between MEM and the register file / HI-LO unit. It replaces the single pipeline register with a DEPTH-entry in-order commit buffer, so results from MEM are never lost while writeback is stalled. It retires one entry per cycle into the register file and architected HI/LO registers. It also provides youngest-first forwarding of pending GPR and HI/LO results to ID.

## Interface
Parameters:
- DATA_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- PC_W, 32, PC width
- DEPTH, 4, buffer entries; power of two, 2..16

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- mem_valid  in  1  MEM offers an entry
- mem_ready  out  1  buffer can accept an entry
- mem_pc  in  PC_W  instruction PC
- mem_rf_we  in  1  GPR write enable
- mem_rf_waddr  in  ADDR_W  GPR destination
- mem_rf_wdata  in  DATA_W  GPR data
- mem_hilo_we  in  2  bit1 = write HI, bit0 = write LO
- mem_hi_wdata, mem_lo_wdata  in  DATA_W each  HI/LO data
- wb_stall  in  1  hold commit this cycle
- flush  in  1  discard all uncommitted entries
- rf_we  out  1  GPR write strobe
- rf_waddr  out  ADDR_W  GPR write address
- rf_wdata  out  DATA_W  GPR write data
- fwd_raddr0, fwd_raddr1  in  ADDR_W each  ID lookup addresses
- fwd_hit0, fwd_hit1  out  1 each  a pending entry matches
- fwd_data0, fwd_data1  out  DATA_W each  forwarded data
- hi_o, lo_o  out  DATA_W each  HI/LO value seen by ID, pending writes included
- debug_wb_pc  out  PC_W  committing PC
- debug_wb_rf_wen  out  4  {4{rf_we}}
- debug_wb_rf_wnum  out  ADDR_W  = rf_waddr
- debug_wb_rf_wdata  out  DATA_W  = rf_wdata

## Operation
- Circular buffer with head/tail pointers (log2 DEPTH bits) and count (log2 DEPTH + 1 bits). Pointers wrap modulo DEPTH.
- Push: mem_valid & mem_ready & !flush. The entry is written at the tail.
- mem_ready = (count != DEPTH) & !rst. It depends only on registered state; there is no combinational path from wb_stall.
- Commit: count != 0 & !wb_stall & !flush. The head entry is popped.
- rf_we = commit & head.rf_we & (head.rf_waddr != 0). rf_waddr, rf_wdata and debug_wb_pc show the head entry when commit = 1, and 0 otherwise.
- Push and commit in the same cycle: both occur and count is unchanged. When count = DEPTH, a same-cycle pop does not raise mem_ready.
- flush: all entries are invalidated, head = tail = 0 and count = 0 at the next edge. Commit and push are suppressed that cycle. HI/LO are unchanged.
- GPR forwarding, per read port:
  - Search valid entries from youngest to oldest for rf_we & waddr == raddr.
  - The first match gives hit = 1 and that entry's data.
  - raddr == 0 never hits. No match gives hit = 0 and data = 0.
  - The entry committing this cycle is still searched.
- HI/LO forwarding: hi_o is the youngest valid entry with hilo_we[1], else architected HI. lo_o follows the same rule with bit0 and LO.

## Timing
- Reset values: all entries invalid, count 0, HI = LO = 0, every output 0, mem_ready 0 while rst is high.
- Latency: an entry accepted in cycle N can commit no earlier than cycle N+1. There is no same-cycle pass-through.
- Throughput: one push and one commit per cycle.
- Commit outputs are combinational from the head entry. The RF and HI/LO update at the edge ending the commit cycle.
- Forwarding outputs are combinational from the buffer contents and fwd_raddr.
- If rst asserts mid-operation, contents are cleared immediately (asynchronous).

## Configuration
- Macro: WB_HILO_EN.
- Defined: each entry stores HI/LO fields and the architected HI/LO registers are instantiated. HI and LO each update on commit of an entry with the matching hilo_we bit; both bits set updates both.
- Undefined: the HI/LO fields and registers are not built, mem_hilo_we and the HI/LO data inputs are ignored, and hi_o = lo_o = 0.

## Test plan
- Back-to-back: push 3 entries (r1=0x11, r2=0x22, r3=0x33) with wb_stall = 0 -> rf_we on cycles 2, 3, 4 in order, debug_wb_rf_wen = 4'hF each time.
- Full/stall: with DEPTH = 4, hold wb_stall and push 5 -> mem_ready = 0 after the 4th push. Release the stall -> 4 in-order commits, mem_ready = 1 one cycle after the first pop.
- Forward priority: pending r5 = 0xA then r5 = 0xB, fwd_raddr0 = 5 -> hit0 = 1, data0 = 0xB. fwd_raddr1 = 0 with a pending r0 write -> hit1 = 0, and no rf_we on r0 commit.
- Flush: 3 pending entries, assert flush with a simultaneous push -> no commit or push that cycle. Next cycle count = 0 and fwd_hit = 0.
- HI/LO (WB_HILO_EN defined): push mult with HI = 0x1, LO = 0x2 under stall -> hi_o = 0x1 and lo_o = 0x2 before commit. After commit they are unchanged, sourced from the architected registers. Undefined -> both 0.
- Reset: assert rst asynchronously mid-stream -> all outputs 0 immediately. After release, the first push commits normally.

Source files
------------

// File: rtl/wb_commit_buf.sv
// wb_commit_buf
// -----------------------------------------------------------------------------
// Writeback stage for the 5-stage MIPS core. It sits between MEM and the
// register file / HI-LO unit. A DEPTH-entry in-order commit buffer holds MEM
// results, so nothing is lost while writeback is stalled. The buffer retires
// one entry per cycle. It also forwards pending GPR and HI/LO results to ID,
// with the youngest entry winning.
//
// Optional feature macro: WB_HILO_EN
//   defined   -> each entry carries HI/LO fields and the architected HI/LO
//                registers are built.
//   undefined -> HI/LO inputs are ignored and hi_o = lo_o = 0.
//
// Ports
//   clk, rst                     rising-edge clock, async active-high reset
//   mem_valid / mem_ready        MEM -> buffer handshake
//   mem_pc, mem_rf_*             entry payload (PC, GPR write)
//   mem_hilo_we, mem_hi/lo_wdata entry payload (HI/LO write)
//   wb_stall                     hold commit this cycle
//   flush                        drop every uncommitted entry
//   rf_we/rf_waddr/rf_wdata      GPR write port, driven by the head entry
//   fwd_raddr0/1 -> fwd_hit0/1, fwd_data0/1   GPR forwarding to ID
//   hi_o, lo_o                   HI/LO as seen by ID, pending writes included
//   debug_wb_*                   commit trace
// -----------------------------------------------------------------------------
module wb_commit_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [PC_W-1:0]   mem_pc,
  input  logic              mem_rf_we,
  input  logic [ADDR_W-1:0] mem_rf_waddr,
  input  logic [DATA_W-1:0] mem_rf_wdata,
  input  logic [1:0]        mem_hilo_we,
  input  logic [DATA_W-1:0] mem_hi_wdata,
  input  logic [DATA_W-1:0] mem_lo_wdata,
  input  logic              wb_stall,
  input  logic              flush,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] fwd_raddr0,
  input  logic [ADDR_W-1:0] fwd_raddr1,
  output logic              fwd_hit0,
  output logic              fwd_hit1,
  output logic [DATA_W-1:0] fwd_data0,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic [PC_W-1:0]   debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PC_W-1:0]   r_pc    [DEPTH];
  logic              r_we    [DEPTH];
  logic [ADDR_W-1:0] r_waddr [DEPTH];
  logic [DATA_W-1:0] r_wdata [DEPTH];

  logic              w_push;
  logic              w_commit;
  logic [PTR_W-1:0]  w_scan_idx;

  // mem_ready depends only on registered state and rst. A pop in the same
  // cycle does not reopen a full buffer, so wb_stall never reaches MEM
  // combinationally.
  assign mem_ready = (r_count != CNT_W'(DEPTH)) & ~rst;
  assign w_push    = mem_valid & mem_ready & ~flush;
  assign w_commit  = (r_count != '0) & ~wb_stall & ~flush;

  // Pointer / occupancy state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)   r_tail <= r_tail + 1'b1;
      if (w_commit) r_head <= r_head + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_commit);
    end
  end

  // Entry payload. Validity is implied by head/count, so a flush does not
  // need to touch the payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_pc[e]    <= '0;
        r_we[e]    <= 1'b0;
        r_waddr[e] <= '0;
        r_wdata[e] <= '0;
      end
    end else if (w_push) begin
      r_pc[r_tail]    <= mem_pc;
      r_we[r_tail]    <= mem_rf_we;
      r_waddr[r_tail] <= mem_rf_waddr;
      r_wdata[r_tail] <= mem_rf_wdata;
    end
  end

  // Commit port: shows the head entry only while it actually retires.
  assign rf_we       = w_commit & r_we[r_head] & (r_waddr[r_head] != '0);
  assign rf_waddr    = w_commit ? r_waddr[r_head] : '0;
  assign rf_wdata    = w_commit ? r_wdata[r_head] : '0;
  assign debug_wb_pc = w_commit ? r_pc[r_head]    : '0;

  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

  // GPR forwarding. The scan walks from oldest (offset 0) to youngest. A later
  // match overwrites an earlier one, so the youngest writer wins. The entry
  // retiring this cycle is still inside the scan window.
  always_comb begin
    fwd_hit0   = 1'b0;
    fwd_hit1   = 1'b0;
    fwd_data0  = '0;
    fwd_data1  = '0;
    w_scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if ((CNT_W'(k) < r_count) && r_we[w_scan_idx]) begin
        if ((fwd_raddr0 != '0) && (r_waddr[w_scan_idx] == fwd_raddr0)) begin
          fwd_hit0  = 1'b1;
          fwd_data0 = r_wdata[w_scan_idx];
        end
        if ((fwd_raddr1 != '0) && (r_waddr[w_scan_idx] == fwd_raddr1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = r_wdata[w_scan_idx];
        end
      end
    end
  end

`ifdef WB_HILO_EN
  logic [1:0]        r_hilo_we [DEPTH];
  logic [DATA_W-1:0] r_hi      [DEPTH];
  logic [DATA_W-1:0] r_lo      [DEPTH];
  logic [DATA_W-1:0] r_arch_hi;
  logic [DATA_W-1:0] r_arch_lo;
  logic [PTR_W-1:0]  w_hl_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        r_hilo_we[e] <= '0;
        r_hi[e]      <= '0;
        r_lo[e]      <= '0;
      end
    end else if (w_push) begin
      r_hilo_we[r_tail] <= mem_hilo_we;
      r_hi[r_tail]      <= mem_hi_wdata;
      r_lo[r_tail]      <= mem_lo_wdata;
    end
  end

  // Architected HI/LO. Flush leaves them alone, because only committed
  // results ever reach them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arch_hi <= '0;
      r_arch_lo <= '0;
    end else if (w_commit) begin
      if (r_hilo_we[r_head][1]) r_arch_hi <= r_hi[r_head];
      if (r_hilo_we[r_head][0]) r_arch_lo <= r_lo[r_head];
    end
  end

  // Youngest pending HI/LO write overrides the architected value.
  always_comb begin
    hi_o     = r_arch_hi;
    lo_o     = r_arch_lo;
    w_hl_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_hl_idx = r_head + PTR_W'(k);
      if (CNT_W'(k) < r_count) begin
        if (r_hilo_we[w_hl_idx][1]) hi_o = r_hi[w_hl_idx];
        if (r_hilo_we[w_hl_idx][0]) lo_o = r_lo[w_hl_idx];
      end
    end
  end
`else
  logic w_unused_hilo;
  assign w_unused_hilo = ^{mem_hilo_we, mem_hi_wdata, mem_lo_wdata};
  assign hi_o = '0;
  assign lo_o = '0;
`endif

endmodule
